// File: rtl/vga_sync_gen_if.sv
// Timing bus of the VGA sync generator.
// master: the generator (drives timing, samples enable).
// slave:  the downstream consumer (drives enable, samples timing).
interface vga_sync_gen_if;
  logic       enable;
  logic       pixel_tick;
  logic [9:0] pixel_cnt;
  logic [9:0] line_cnt;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  enable,
    output pixel_tick, pixel_cnt, line_cnt, hsync, vsync,
           video_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    output enable,
    input  pixel_tick, pixel_cnt, line_cnt, hsync, vsync,
           video_on, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, pixel/line counters, H and V phase
// FSMs, registered sync/blanking and line/frame start pulses.
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN builds an 8-bit frame
// counter; without it frame_cnt is tied to zero.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  vga_sync_gen_if.master bus
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [3:0]  DIV_LAST     = 4'(CLK_DIV - 1);

  // Every phase must be at least one unit wide for the phase FSMs to step.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("vga_sync_gen: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  logic [3:0] r_div;
  logic [9:0] r_pixel_cnt;
  logic [9:0] r_line_cnt;
  phase_t     r_h_state;
  phase_t     r_v_state;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_tick;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_pixel_nxt;
  logic [9:0] w_line_nxt;
  phase_t     w_h_nxt;
  phase_t     w_v_nxt;

  assign w_tick      = bus.enable && (r_div == DIV_LAST);
  assign w_h_wrap    = (r_pixel_cnt == H_LAST);
  assign w_v_wrap    = (r_line_cnt == V_LAST);
  assign w_pixel_nxt = w_h_wrap ? '0 : r_pixel_cnt + 10'd1;
  assign w_line_nxt  = !w_h_wrap ? r_line_cnt :
                       (w_v_wrap ? '0 : r_line_cnt + 10'd1);

  // Phase transitions keyed on the next-state counts, so sync and blanking
  // land on the same edge as the count they belong to.
  always_comb begin
    w_h_nxt = r_h_state;
    unique case (r_h_state)
      PH_ACTIVE: if (32'(w_pixel_nxt) == H_ACTIVE)     w_h_nxt = PH_FRONT;
      PH_FRONT:  if (32'(w_pixel_nxt) == H_SYNC_START) w_h_nxt = PH_SYNC;
      PH_SYNC:   if (32'(w_pixel_nxt) == H_SYNC_END)   w_h_nxt = PH_BACK;
      PH_BACK:   if (w_pixel_nxt == '0)                w_h_nxt = PH_ACTIVE;
    endcase
    w_v_nxt = r_v_state;
    if (w_h_wrap) begin
      unique case (r_v_state)
        PH_ACTIVE: if (32'(w_line_nxt) == V_ACTIVE)     w_v_nxt = PH_FRONT;
        PH_FRONT:  if (32'(w_line_nxt) == V_SYNC_START) w_v_nxt = PH_SYNC;
        PH_SYNC:   if (32'(w_line_nxt) == V_SYNC_END)   w_v_nxt = PH_BACK;
        PH_BACK:   if (w_line_nxt == '0)                w_v_nxt = PH_ACTIVE;
      endcase
    end
  end

  // Divider, counters, phase FSMs and registered outputs; pulses clear on
  // every clock so they never outlive one clock, even while frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_pixel_cnt   <= H_LAST;
      r_line_cnt    <= V_LAST;
      r_h_state     <= PH_BACK;
      r_v_state     <= PH_BACK;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (bus.enable) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 4'd1;
      end
      if (w_tick) begin
        r_pixel_cnt   <= w_pixel_nxt;
        r_line_cnt    <= w_line_nxt;
        r_h_state     <= w_h_nxt;
        r_v_state     <= w_v_nxt;
        r_hsync       <= (w_h_nxt == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        r_vsync       <= (w_v_nxt == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        r_video_on    <= (w_h_nxt == PH_ACTIVE) && (w_v_nxt == PH_ACTIVE);
        r_line_start  <= w_h_wrap;
        r_frame_start <= w_h_wrap && w_v_wrap;
      end
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Frame counter advances on the edge that raises frame_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`else
  assign bus.frame_cnt = '0;
`endif

  assign bus.pixel_tick  = w_tick;
  assign bus.pixel_cnt   = r_pixel_cnt;
  assign bus.line_cnt    = r_line_cnt;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.video_on    = r_video_on;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance checked against a
// table of hand-computed positions plus freeze/reset sequences, and a
// tiny-geometry CLK_DIV=1 instance checked cycle by cycle against a model
// across 257 frames with enable gaps.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #10 clk = ~clk;

  vga_sync_gen_if a_if ();
  vga_sync_gen_if b_if ();

  vga_sync_gen #(.CLK_DIV(2)) u_dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (a_if)
  );

  vga_sync_gen #(
    .CLK_DIV  (1),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (5), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (b_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line-0 statistics for instance A, in clocks.
  int a_hs_low0 = 0;
  int a_von0    = 0;
  always @(negedge clk) begin
    if (!rst_a && a_if.line_cnt == 10'd0) begin
      if (!a_if.hsync)   a_hs_low0++;
      if (a_if.video_on) a_von0++;
    end
  end

  int a_el;  // clocks since (0,0) first appeared on instance A

  // Called at a negedge with rst_a high and enable high.
  task automatic a_restart(input string tag);
    check({tag, " rst pixel"}, a_if.pixel_cnt, 64'd799);
    check({tag, " rst line"},  a_if.line_cnt, 64'd524);
    check({tag, " rst syncs"}, {a_if.hsync, a_if.vsync}, 64'b11);
    check({tag, " rst flags"}, {a_if.video_on, a_if.line_start, a_if.frame_start}, 64'b000);
    check({tag, " rst fcnt"},  a_if.frame_cnt, 64'd0);
    rst_a = 1'b0;
    #1 check({tag, " tick clk1"}, a_if.pixel_tick, 64'd0);
    @(negedge clk);
    check({tag, " tick clk2"}, a_if.pixel_tick, 64'd1);
    check({tag, " hold 799"}, a_if.pixel_cnt, 64'd799);
    @(negedge clk);
    check({tag, " first pos"}, {a_if.pixel_cnt, a_if.line_cnt}, 64'd0);
    check({tag, " first flags"},
          {a_if.hsync, a_if.vsync, a_if.video_on, a_if.line_start, a_if.frame_start},
          64'b11111);
    check({tag, " first fcnt"}, a_if.frame_cnt, FC_EN ? 64'd1 : 64'd0);
    @(negedge clk);
    check({tag, " pulses 1clk"}, {a_if.line_start, a_if.frame_start}, 64'b00);
    a_el = 1;
  endtask

  typedef struct {
    int   px;
    int   py;
    logic hs;
    logic vs;
    logic von;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[10];

  // Instance B model state.
  int   mpx, mpy, mfc, frames;
  logic mls, mfs;

  function automatic logic [63:0] b_model_vec();
    logic hs, vs, von;
    logic [7:0] fc;
    hs  = (mpx >= 10 && mpx <= 12);
    vs  = !(mpy >= 6 && mpy <= 7);
    von = (mpx < 8 && mpy < 5);
    fc  = FC_EN ? 8'(mfc % 256) : 8'd0;
    return {29'd0, 10'(mpx), 10'(mpy), hs, vs, von, mls, mfs, fc};
  endfunction

  function automatic logic [63:0] b_dut_vec();
    return {29'd0, b_if.pixel_cnt, b_if.line_cnt, b_if.hsync, b_if.vsync,
            b_if.video_on, b_if.line_start, b_if.frame_start, b_if.frame_cnt};
  endfunction

  initial begin
    int   target;
    int   lim;
    bit   hit;
    int   changed;
    int   ticks;
    int   n;
    logic en;

    //            px   py  hs vs von ls fs
    tbl[0] = '{   1,   0, 1, 1, 1, 0, 0};
    tbl[1] = '{ 639,   0, 1, 1, 1, 0, 0};
    tbl[2] = '{ 640,   0, 1, 1, 0, 0, 0};
    tbl[3] = '{ 655,   0, 1, 1, 0, 0, 0};
    tbl[4] = '{ 656,   0, 0, 1, 0, 0, 0};
    tbl[5] = '{ 751,   0, 0, 1, 0, 0, 0};
    tbl[6] = '{ 752,   0, 1, 1, 0, 0, 0};
    tbl[7] = '{ 799,   0, 1, 1, 0, 0, 0};
    tbl[8] = '{   0,   1, 1, 1, 1, 1, 0};
    tbl[9] = '{ 300,  10, 1, 1, 1, 0, 0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.enable = 1'b1;
    b_if.enable = 1'b0;
    repeat (3) @(negedge clk);

    // Instance A: reset release and first tick.
    a_restart("A start");

    // Instance A: walk the position table.
    for (int i = 0; i < 10; i++) begin
      target = tbl[i].py * 800 + tbl[i].px;
      lim    = 2 * target + 8;
      hit    = 1'b0;
      while (a_el < lim && !hit) begin
        @(negedge clk);
        a_el++;
        if (a_if.pixel_cnt == 10'(tbl[i].px) && a_if.line_cnt == 10'(tbl[i].py)) hit = 1'b1;
      end
      check($sformatf("A vec%0d reached", i), hit, 64'd1);
      check($sformatf("A vec%0d clocks", i), a_el, 64'(2 * target));
      check($sformatf("A vec%0d outputs", i),
            {a_if.hsync, a_if.vsync, a_if.video_on, a_if.line_start, a_if.frame_start},
            {59'd0, tbl[i].hs, tbl[i].vs, tbl[i].von, tbl[i].ls, tbl[i].fs});
      if (i == 8) begin
        check("A line0 hsync low clocks", a_hs_low0, 64'd192);
        check("A line0 video_on clocks", a_von0, 64'd1280);
      end
    end

    // Instance A: freeze at (300,10) for 10 clocks.
    a_if.enable = 1'b0;
    changed = 0;
    ticks   = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_if.pixel_tick) ticks++;
      if (a_if.pixel_cnt != 10'd300 || a_if.line_cnt != 10'd10 || !a_if.video_on ||
          !a_if.hsync || !a_if.vsync || a_if.line_start || a_if.frame_start) changed++;
    end
    check("A freeze ticks", ticks, 64'd0);
    check("A freeze outputs", changed, 64'd0);
    a_if.enable = 1'b1;
    n = 0;
    while (n < 6 && a_if.pixel_cnt == 10'd300) begin
      @(negedge clk);
      n++;
    end
    check("A resume pixel", a_if.pixel_cnt, 64'd301);
    check("A resume clocks", n, 64'd2);

    // Instance A: asynchronous reset between edges.
    #5 rst_a = 1'b1;
    #1;
    check("A async pos", {a_if.pixel_cnt, a_if.line_cnt}, {44'd0, 10'd799, 10'd524});
    check("A async flags",
          {a_if.hsync, a_if.vsync, a_if.video_on, a_if.line_start, a_if.frame_start},
          64'b11000);
    @(negedge clk);
    a_restart("A again");

    // Instance B: reset state, then cycle-accurate model for 257 frames.
    mpx = 14; mpy = 9; mfc = 0; frames = 0; mls = 1'b0; mfs = 1'b0;
    check("B rst tick", b_if.pixel_tick, 64'd0);
    check("B rst state", b_dut_vec(), b_model_vec());
    rst_b = 1'b0;
    for (int c = 0; c < 45000 && frames < 257; c++) begin
      en = !((c % 37) == 5 || (c % 53) == 20);
      b_if.enable = en;
      #1 check("B tick", b_if.pixel_tick, {63'd0, en});
      if (en) begin
        mls = (mpx == 14);
        mfs = (mpx == 14 && mpy == 9);
        if (mpx == 14) begin
          mpx = 0;
          if (mpy == 9) begin
            mpy = 0;
            mfc++;
            frames++;
          end else begin
            mpy++;
          end
        end else begin
          mpx++;
        end
      end else begin
        mls = 1'b0;
        mfs = 1'b0;
      end
      @(negedge clk);
      check($sformatf("B state c%0d", c), b_dut_vec(), b_model_vec());
    end
    check("B fcnt after 257 wraps", b_if.frame_cnt, FC_EN ? 64'd1 : 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
